vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Pixel stage directly downstream of core_480. Consumes its beam position (Sx, Sy), data-enable and syncs, and produces RGB444 pixel data.
- Four selectable test patterns, one of them an animated bouncing square.
- Syncs and DE are re-timed so they stay aligned with the 2-stage pixel pipeline, then drive the DAC/pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- SQ_SIZE, 32, bouncing-square edge length in pixels.
- SQ_SPEED, 2, square displacement per frame per axis, in pixels.
- SYNC_IDLE, 1'b1, inactive level of hsync/vsync, driven during reset.

Ports:
- i_VGA_CLOCK  in  1  pixel clock, 25.175 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_de  in  1  data enable from core_480.
- i_hsync  in  1  hsync from core_480.
- i_vsync  in  1  vsync from core_480.
- i_Sx  in  10  horizontal position, 0-799.
- i_Sy  in  10  vertical position, 0-524.
- i_mode  in  2  pattern request. 0 = bars, 1 = checker, 2 = gradient, 3 = square.
- o_r  out  4  red.
- o_g  out  4  green.
- o_b  out  4  blue.
- o_de  out  1  i_de delayed 2 cycles.
- o_hsync  out  1  i_hsync delayed 2 cycles.
- o_vsync  out  1  i_vsync delayed 2 cycles.
- o_frame_cnt  out  8  frames completed, wraps 255 -> 0.

Behaviour:
- Clock is i_VGA_CLOCK. Reset is asynchronous, active-low on i_rst_n. All flops reset asynchronously.
- Reset values:
  - o_r/o_g/o_b = 0, o_de = 0.
  - o_hsync = o_vsync = SYNC_IDLE, and both pipeline stages hold SYNC_IDLE.
  - o_frame_cnt = 0, active mode = 0.
  - Square at (0,0), direction +x/+y.
- Latency:
  - Every output is exactly 2 cycles after the inputs it derives from.
  - Stage 1 registers pattern colour and the delayed DE/syncs.
  - Stage 2 applies blanking: RGB forced to 0 when the stage-2 DE is 0.
- frame_tick: single-cycle pulse when i_Sx == 0 and i_Sy == V_ACTIVE (first blanking line). Exactly one per frame. On frame_tick:
  - active mode <= i_mode.
  - o_frame_cnt increments.
  - Square position updates.
- Mode changes on i_mode mid-frame have no effect until the next frame_tick, so there is no tearing.
- Pattern 0, colour bars:
  - 8 bars of H_ACTIVE/8 = 80 px, index chosen by compare chain (no divider).
  - Colours left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- Pattern 1, checker: colour = (Sx[5] ^ Sy[5]) ? FFF : 000.
- Pattern 2, gradient: r = Sx[9:6], g = Sy[8:5], b = o_frame_cnt[3:0].
- Pattern 3, square:
  - Colour is F80 when pos_x <= Sx < pos_x+SQ_SIZE and pos_y <= Sy < pos_y+SQ_SIZE; otherwise 004.
  - Motion on each frame_tick, per axis, 10-bit unsigned arithmetic:
    - Direction +, pos+SQ_SPEED >= limit: pos <= limit, direction becomes −.
    - Direction −, pos <= SQ_SPEED: pos <= 0, direction becomes +.
    - Otherwise: pos += / −= SQ_SPEED.
  - limit = H_ACTIVE−SQ_SIZE (608) for x, V_ACTIVE−SQ_SIZE (448) for y.
  - Both axes update in the same tick. Hitting a corner reverses both directions.
- Inputs with Sx >= H_ACTIVE or Sy >= V_ACTIVE are blanked via DE. Pattern logic needs no special case for them.
- Reset mid-frame: outputs return to reset values immediately. After release, first valid pixels appear 2 cycles after i_de rises.

Optional Feature:
- Macro VGA_PATTERN_BORDER_EN.
- Defined: pixels with Sx == 0, Sx == H_ACTIVE−1, Sy == 0 or Sy == V_ACTIVE−1 are forced to FFF in every mode (monitor alignment aid). Blanking still has priority.
- Undefined: no border logic is present; patterns are as above.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults.
  - typedef rgb444_t as a struct of 4-bit r, g, b.
  - enum pattern_mode_e {PAT_BARS, PAT_CHECKER, PAT_GRADIENT, PAT_SQUARE}.
  - 8-entry bar colour constant array.
- One sub-module, vga_square_mover:
  - Inputs: clock, reset, frame_tick.
  - Outputs: pos_x, pos_y.
  - Owns the bounce state (position and direction flops).

Test Plan:
- Reset held, then released with core_480 running → o_hsync/o_vsync = 1 during reset. o_de, RGB, o_frame_cnt all 0.
- Mode 0, beam at Sx=85, Sy=10, DE=1 → RGB = FF0 exactly 2 cycles later. At Sx=639: 000. At Sx=0: FFF.
- Mode 1, (Sx,Sy) = (32,0) → FFF. (32,32) → 000. Any pixel with DE=0 → 000.
- Switch i_mode 0→1 at Sy=100 → bars continue to the end of the frame. Checker starts from the frame after the tick at Sy=480. o_frame_cnt increments by 1.
- Mode 3, run 310 frames → pos_x reaches 608 at frame 304 and then decreases (606 at 305). pos_y clamps at 448 at frame 224 and reverses. o_frame_cnt wraps 255 → 0.
- With VGA_PATTERN_BORDER_EN, mode 3 → pixel (0,200) = FFF, (320,479) = FFF. Without the macro, the same pixels show the normal pattern colour.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel stage.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned SQ_SIZE_DEF  = 32;
    localparam int unsigned SQ_SPEED_DEF = 2;
    localparam int unsigned POS_W        = 10;
    localparam int unsigned RGB_W        = 4;
    localparam int unsigned FRAME_W      = 8;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_SQUARE   = 2'd3
    } pattern_mode_e;

    localparam rgb444_t RGB_WHITE = rgb444_t'(12'hFFF);
    localparam rgb444_t RGB_BLACK = rgb444_t'(12'h000);
    localparam rgb444_t SQ_FG     = rgb444_t'(12'hF80);
    localparam rgb444_t SQ_BG     = rgb444_t'(12'h004);

    localparam rgb444_t BAR_COLOURS [8] = '{
        rgb444_t'(12'hFFF), rgb444_t'(12'hFF0), rgb444_t'(12'h0FF), rgb444_t'(12'h0F0),
        rgb444_t'(12'hF0F), rgb444_t'(12'hF00), rgb444_t'(12'h00F), rgb444_t'(12'h000)
    };

    // One bounce step for a single axis; returns {dir_up, pos}.
    function automatic logic [POS_W:0] bounce_step(
        input logic [POS_W-1:0] pos,
        input logic             dir_up,
        input logic [POS_W-1:0] limit,
        input logic [POS_W-1:0] speed
    );
        logic [POS_W:0] res;
        if (dir_up) begin
            if (pos + speed >= limit) res = {1'b0, limit};
            else                      res = {1'b1, pos + speed};
        end else begin
            if (pos <= speed) res = {1'b1, POS_W'(0)};
            else              res = {1'b0, pos - speed};
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_square_mover.sv
// Bouncing-square position/direction state, advanced once per frame tick.
module vga_square_mover
    import vga_pkg::*;
#(
    parameter int unsigned LIMIT_X  = H_ACTIVE_DEF - SQ_SIZE_DEF,
    parameter int unsigned LIMIT_Y  = V_ACTIVE_DEF - SQ_SIZE_DEF,
    parameter int unsigned SQ_SPEED = SQ_SPEED_DEF
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y
);

    logic           dir_x;
    logic           dir_y;
    logic [POS_W:0] step_x;
    logic [POS_W:0] step_y;

    assign step_x = bounce_step(pos_x, dir_x, POS_W'(LIMIT_X), POS_W'(SQ_SPEED));
    assign step_y = bounce_step(pos_y, dir_y, POS_W'(LIMIT_Y), POS_W'(SQ_SPEED));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x <= '0;
            pos_y <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (frame_tick) begin
            {dir_x, pos_x} <= step_x;
            {dir_y, pos_y} <= step_y;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage RGB444 test-pattern pipeline behind core_480 with re-timed syncs/DE.
// Optional monitor-alignment border enabled by defining VGA_PATTERN_BORDER_EN.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
    parameter int unsigned SQ_SIZE   = SQ_SIZE_DEF,
    parameter int unsigned SQ_SPEED  = SQ_SPEED_DEF,
    parameter logic        SYNC_IDLE = 1'b1
)(
    input  logic               i_VGA_CLOCK,
    input  logic               i_rst_n,
    input  logic               i_de,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic [POS_W-1:0]   i_Sx,
    input  logic [POS_W-1:0]   i_Sy,
    input  logic [1:0]         i_mode,
    output logic [RGB_W-1:0]   o_r,
    output logic [RGB_W-1:0]   o_g,
    output logic [RGB_W-1:0]   o_b,
    output logic               o_de,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic [FRAME_W-1:0] o_frame_cnt
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;

    pattern_mode_e      mode_q;
    logic [FRAME_W-1:0] frame_cnt;
    logic               frame_tick;
    logic [POS_W-1:0]   pos_x;
    logic [POS_W-1:0]   pos_y;
    logic [2:0]         bar_idx;
    logic               in_sq;
    rgb444_t            pat;
    rgb444_t            pix;
    rgb444_t            col1;
    logic               de1;
    logic               hs1;
    logic               vs1;

    // First blanking line start: the single per-frame update point.
    assign frame_tick = (i_Sx == POS_W'(0)) && (i_Sy == POS_W'(V_ACTIVE));

    vga_square_mover #(
        .LIMIT_X  (H_ACTIVE - SQ_SIZE),
        .LIMIT_Y  (V_ACTIVE - SQ_SIZE),
        .SQ_SPEED (SQ_SPEED)
    ) u_mover (
        .clk        (i_VGA_CLOCK),
        .rst_n      (i_rst_n),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y)
    );

    always_ff @(posedge i_VGA_CLOCK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q    <= PAT_BARS;
            frame_cnt <= '0;
        end else if (frame_tick) begin
            mode_q    <= pattern_mode_e'(i_mode);
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    // Bar index by descending compare chain; last hit is the lowest bar.
    always_comb begin
        bar_idx = 3'd7;
        for (int k = 6; k >= 0; k--) begin
            if (i_Sx < POS_W'(BAR_W * (k + 1))) bar_idx = 3'(k);
        end
    end

    assign in_sq = (i_Sx >= pos_x) && (i_Sx < pos_x + POS_W'(SQ_SIZE)) &&
                   (i_Sy >= pos_y) && (i_Sy < pos_y + POS_W'(SQ_SIZE));

    always_comb begin
        pat = RGB_BLACK;
        case (mode_q)
            PAT_BARS:     pat = BAR_COLOURS[bar_idx];
            PAT_CHECKER:  pat = (i_Sx[5] ^ i_Sy[5]) ? RGB_WHITE : RGB_BLACK;
            PAT_GRADIENT: pat = '{r: i_Sx[9:6], g: i_Sy[8:5], b: frame_cnt[3:0]};
            PAT_SQUARE:   pat = in_sq ? SQ_FG : SQ_BG;
            default:      pat = RGB_BLACK;
        endcase
    end

`ifdef VGA_PATTERN_BORDER_EN
    logic border_hit;
    assign border_hit = (i_Sx == POS_W'(0)) || (i_Sx == POS_W'(H_ACTIVE - 1)) ||
                        (i_Sy == POS_W'(0)) || (i_Sy == POS_W'(V_ACTIVE - 1));
    assign pix = border_hit ? RGB_WHITE : pat;
`else
    assign pix = pat;
`endif

    // Stage 1: pattern colour and delayed control.
    always_ff @(posedge i_VGA_CLOCK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col1 <= RGB_BLACK;
            de1  <= 1'b0;
            hs1  <= SYNC_IDLE;
            vs1  <= SYNC_IDLE;
        end else begin
            col1 <= pix;
            de1  <= i_de;
            hs1  <= i_hsync;
            vs1  <= i_vsync;
        end
    end

    // Stage 2: blanking and pin drive.
    always_ff @(posedge i_VGA_CLOCK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_r         <= '0;
            o_g         <= '0;
            o_b         <= '0;
            o_de        <= 1'b0;
            o_hsync     <= SYNC_IDLE;
            o_vsync     <= SYNC_IDLE;
            o_frame_cnt <= '0;
        end else begin
            o_r         <= de1 ? col1.r : '0;
            o_g         <= de1 ? col1.g : '0;
            o_b         <= de1 ? col1.b : '0;
            o_de        <= de1;
            o_hsync     <= hs1;
            o_vsync     <= vs1;
            o_frame_cnt <= frame_cnt;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen with a compressed-beam behavioural model.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_de, i_hsync, i_vsync;
    logic [9:0] i_Sx, i_Sy;
    logic [1:0] i_mode;
    logic [3:0] o_r, o_g, o_b;
    logic       o_de, o_hsync, o_vsync;
    logic [7:0] o_frame_cnt;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .i_VGA_CLOCK (clk),
        .i_rst_n     (rst_n),
        .i_de        (i_de),
        .i_hsync     (i_hsync),
        .i_vsync     (i_vsync),
        .i_Sx        (i_Sx),
        .i_Sy        (i_Sy),
        .i_mode      (i_mode),
        .o_r         (o_r),
        .o_g         (o_g),
        .o_b         (o_b),
        .o_de        (o_de),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_frame_cnt (o_frame_cnt)
    );

`ifdef VGA_PATTERN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    typedef struct {
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        int          cnt;
    } exp_t;

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    int   checks = 0;
    int   errors = 0;
    int   m_mode, m_cnt, m_px, m_py, m_dx, m_dy;
    int   req_mode;
    exp_t pipe0, pipe1;
    logic [11:0] obs_rgb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [11:0] model_pix(input int sx, input int sy, input bit de,
                                              input int mode, input int px, input int py,
                                              input int cnt);
        int idx;
        if (!de) return 12'h000;
        if (BORDER && (sx == 0 || sx == 639 || sy == 0 || sy == 479)) return 12'hFFF;
        case (mode)
            0: begin
                idx = sx / 80;
                if (idx > 7) idx = 7;
                return bars[idx];
            end
            1: return (((sx / 32) % 2) != ((sy / 32) % 2)) ? 12'hFFF : 12'h000;
            2: return {4'((sx / 64) % 16), 4'((sy / 32) % 16), 4'(cnt % 16)};
            default: return (sx >= px && sx < px + 32 && sy >= py && sy < py + 32)
                            ? 12'hF80 : 12'h004;
        endcase
    endfunction

    // Bounce along one axis: positions live in [0, limit].
    task automatic move_axis(input int p, input int d, input int limit,
                             output int np, output int nd);
        np = p + 2 * d;
        nd = d;
        if (np >= limit) begin np = limit; nd = -1; end
        else if (np <= 0) begin np = 0; nd = 1; end
    endtask

    task automatic reset_model();
        m_mode = 0; m_cnt = 0;
        m_px = 0; m_py = 0; m_dx = 1; m_dy = 1;
        pipe0 = '{rgb: 12'h000, de: 1'b0, hs: 1'b1, vs: 1'b1, cnt: 0};
        pipe1 = pipe0;
    endtask

    // One beam cycle: check outputs due now, then present new inputs.
    task automatic step(input bit de, input bit hs, input bit vs,
                        input int sx, input int sy, input int mode);
        int nx, ndx, ny, ndy;
        @(negedge clk);
        obs_rgb = {o_r, o_g, o_b};
        check("rgb", 32'(obs_rgb), 32'(pipe1.rgb));
        check("de", 32'(o_de), 32'(pipe1.de));
        check("hsync", 32'(o_hsync), 32'(pipe1.hs));
        check("vsync", 32'(o_vsync), 32'(pipe1.vs));
        check("frame_cnt", 32'(o_frame_cnt), 32'(pipe1.cnt));
        pipe1 = pipe0;
        pipe0.rgb = model_pix(sx, sy, de, m_mode, m_px, m_py, m_cnt);
        pipe0.de  = de;
        pipe0.hs  = hs;
        pipe0.vs  = vs;
        if (sx == 0 && sy == 480) begin
            m_mode = mode;
            m_cnt  = (m_cnt + 1) % 256;
            move_axis(m_px, m_dx, 608, nx, ndx);
            move_axis(m_py, m_dy, 448, ny, ndy);
            m_px = nx; m_dx = ndx; m_py = ny; m_dy = ndy;
        end
        pipe0.cnt = m_cnt;
        i_de = de; i_hsync = hs; i_vsync = vs;
        i_Sx = 10'(sx); i_Sy = 10'(sy); i_mode = 2'(mode);
    endtask

    task automatic pix(input int sx, input int sy);
        step((sx < 640 && sy < 480), 1'($urandom), 1'($urandom), sx, sy, req_mode);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b1, 700, 500, req_mode);
    endtask

    task automatic tick();
        step(1'b0, 1'b1, 1'b0, 0, 480, req_mode);
    endtask

    // Pixel followed by two idle cycles so obs_rgb holds its output.
    task automatic pix_lit(input string name, input bit de, input int sx, input int sy,
                           input logic [11:0] lit);
        step(de, 1'b1, 1'b1, sx, sy, req_mode);
        idle();
        idle();
        check(name, 32'(obs_rgb), 32'(lit));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_model();
        for (int i = 0; i < cycles; i++) begin
            check("rst_rgb", 32'({o_r, o_g, o_b}), 32'h0);
            check("rst_de", 32'(o_de), 32'h0);
            check("rst_hsync", 32'(o_hsync), 32'h1);
            check("rst_vsync", 32'(o_vsync), 32'h1);
            check("rst_cnt", 32'(o_frame_cnt), 32'h0);
            @(negedge clk);
            i_de = 1'($urandom); i_hsync = 1'($urandom); i_vsync = 1'($urandom);
            i_Sx = 10'($urandom_range(799)); i_Sy = 10'($urandom_range(524));
            i_mode = 2'($urandom);
        end
        i_de = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1;
        i_Sx = 10'd700; i_Sy = 10'd500;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        i_de = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1;
        i_Sx = '0; i_Sy = '0; i_mode = '0;
        req_mode = 0;
        reset_model();
        #2 rst_n = 1'b0;
        do_reset(4);

        // Bars after reset, then deferred switch to checker.
        pix_lit("bar_85", 1'b1, 85, 10, 12'hFF0);
        pix_lit("bar_639", 1'b1, 639, 10, BORDER ? 12'hFFF : 12'h000);
        pix_lit("bar_0", 1'b1, 0, 10, 12'hFFF);
        req_mode = 1;
        pix_lit("bar_hold", 1'b1, 200, 100, 12'h0FF);
        tick();
        idle();
        idle();
        check("cnt_after_tick", 32'(o_frame_cnt), 32'd1);
        pix_lit("chk_32_0", 1'b1, 32, 0, 12'hFFF);
        pix_lit("chk_32_32", 1'b1, 32, 32, 12'h000);
        pix_lit("chk_de0", 1'b0, 32, 0, 12'h000);

        // Square with border candidates; square sits at (4,4).
        req_mode = 3;
        tick();
        pix_lit("sq_0_200", 1'b1, 0, 200, BORDER ? 12'hFFF : 12'h004);
        pix_lit("sq_320_479", 1'b1, 320, 479, BORDER ? 12'hFFF : 12'h004);
        pix_lit("sq_inside", 1'b1, 10, 10, 12'hF80);

        req_mode = 2;
        tick();
        pix_lit("grad_130_100", 1'b1, 130, 100, 12'h233);

        // Mid-frame reset, then long bounce run.
        pix(300, 200);
        do_reset(3);
        req_mode = 3;
        for (int f = 1; f <= 310; f++) begin
            tick();
            pix(m_px > 0 ? m_px - 1 : 700, m_py + 5);
            pix(m_px, m_py);
            pix(m_px + 31, m_py + 31);
            pix(m_px + 32, m_py);
            pix(m_px + 5, m_py + 32);
            pix($urandom_range(799), $urandom_range(524));
            if (f == 224) check("model_py_224", 32'(m_py), 32'd448);
            if (f == 256) check("model_cnt_wrap", 32'(m_cnt), 32'd0);
            if (f == 304) begin
                check("model_px_304", 32'(m_px), 32'd608);
                pix_lit("sq_edge_608", 1'b1, 608, m_py, 12'hF80);
                pix_lit("sq_edge_607", 1'b1, 607, m_py, 12'h004);
            end
            if (f == 305) check("model_px_305", 32'(m_px), 32'd606);
        end

        // Random beam with occasional frame ticks and mode requests.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) begin
                req_mode = $urandom_range(3);
                tick();
            end else begin
                pix($urandom_range(799), $urandom_range(524));
            end
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
